phys_reg_map_table_wide: RTL

- Superscalar successor to the single-lane rename map table. It renames RENAME_WIDTH instructions per cycle, with intra-group bypass on reads.
- It keeps a circular buffer of CHECKPOINTS snapshots, allocated at tail and reclaimed at head.
- Branch resolution can be out of order. Head lazily skips resolved snapshots.
- Sits in core -> dispatch_unit, between decode and the ROB/free list.

---
 rtl/core_types_pkg.sv | 45 ++++
 rtl/rename_bypass_net.sv | 41 ++++
 rtl/phys_reg_map_table_wide.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core types for the rename stage: tag widths, checkpoint pointer and
// snapshot types used by the wide rename map table.
package core_types_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int PHYS_TAG_W    = 6;
    localparam int ROB_IDX_W     = 6;
    localparam int RENAME_WIDTH  = 2;
    localparam int CHECKPOINTS   = 4;

    localparam int ARCH_TAG_W    = $clog2(NUM_ARCH_REGS);
    localparam int CKPT_IDX_W    = $clog2(CHECKPOINTS);
    localparam int CKPT_PTR_W    = CKPT_IDX_W + 1;
    localparam int LANE_IDX_W    = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1;

    typedef logic [ARCH_TAG_W-1:0] arch_reg_tag_t;
    typedef logic [PHYS_TAG_W-1:0] phys_reg_tag_t;
    typedef logic [ROB_IDX_W-1:0]  ROB_index_t;

    // Extra MSB distinguishes full from empty when the index bits match.
    typedef logic [CKPT_PTR_W-1:0] checkpoint_ptr_t;

    typedef phys_reg_tag_t [NUM_ARCH_REGS-1:0] map_array_t;

    typedef struct packed {
        logic       valid;
        ROB_index_t rob;
        map_array_t map;
    } map_snapshot_t;

    function automatic map_array_t identity_map();
        map_array_t m;
        m = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            m[i] = PHYS_TAG_W'(i);
        end
        return m;
    endfunction

    // Width of the pointer makes the add wrap modulo 2*CHECKPOINTS.
    function automatic checkpoint_ptr_t ptr_inc(input checkpoint_ptr_t p);
        return p + CKPT_PTR_W'(1);
    endfunction

endpackage

// File: rtl/rename_bypass_net.sv
// Per-lane read-port resolution for a rename group: working-map lookup with
// override by older lanes of the same group that rename the same arch tag.
module rename_bypass_net
    import core_types_pkg::*;
(
    input  logic [NUM_ARCH_REGS-1:0][PHYS_TAG_W-1:0] working,
    input  logic [RENAME_WIDTH-1:0][ARCH_TAG_W-1:0]  rd_src0_arch,
    input  logic [RENAME_WIDTH-1:0][ARCH_TAG_W-1:0]  rd_src1_arch,
    input  logic [RENAME_WIDTH-1:0][ARCH_TAG_W-1:0]  rd_dest_arch,
    input  logic [RENAME_WIDTH-1:0]                  rename_valid,
    input  logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0]  rename_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0]  src0_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0]  src1_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0]  old_dest_phys
);

    // Ascending lane scan: the youngest older lane is applied last and wins.
    always_comb begin
        src0_phys     = '0;
        src1_phys     = '0;
        old_dest_phys = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            src0_phys[k]     = working[rd_src0_arch[k]];
            src1_phys[k]     = working[rd_src1_arch[k]];
            old_dest_phys[k] = working[rd_dest_arch[k]];
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                src0_phys[k] = ((j < k) && rename_valid[j] && (rd_dest_arch[j] == rd_src0_arch[k]))
                               ? rename_phys[j] : src0_phys[k];
                src1_phys[k] = ((j < k) && rename_valid[j] && (rd_dest_arch[j] == rd_src1_arch[k]))
                               ? rename_phys[j] : src1_phys[k];
                old_dest_phys[k] = ((j < k) && rename_valid[j] && (rd_dest_arch[j] == rd_dest_arch[k]))
                                   ? rename_phys[j] : old_dest_phys[k];
            end
            // Arch reg 0 is hardwired; a same-group rename of r0 must not leak through.
            src0_phys[k]     = (rd_src0_arch[k] == '0) ? '0 : src0_phys[k];
            src1_phys[k]     = (rd_src1_arch[k] == '0) ? '0 : src1_phys[k];
            old_dest_phys[k] = (rd_dest_arch[k] == '0) ? '0 : old_dest_phys[k];
        end
    end

endmodule

// File: rtl/phys_reg_map_table_wide.sv
// Superscalar rename map table with a circular buffer of branch snapshots.
// Define MAP_TABLE_CHECK_EN to compile in the protocol checks driving DUT_error.
module phys_reg_map_table_wide
    import core_types_pkg::*;
(
    input  logic                                    CLK,
    input  logic                                    nRST,
    output logic                                    DUT_error,
    input  logic [RENAME_WIDTH-1:0][ARCH_TAG_W-1:0] rd_src0_arch,
    input  logic [RENAME_WIDTH-1:0][ARCH_TAG_W-1:0] rd_src1_arch,
    input  logic [RENAME_WIDTH-1:0][ARCH_TAG_W-1:0] rd_dest_arch,
    output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0] rd_src0_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0] rd_src1_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0] rd_old_dest_phys,
    input  logic [RENAME_WIDTH-1:0]                 rename_valid,
    input  logic [RENAME_WIDTH-1:0][PHYS_TAG_W-1:0] rename_phys,
    input  logic                                    save_valid,
    input  logic [LANE_IDX_W-1:0]                   save_lane,
    input  logic [ROB_IDX_W-1:0]                    save_rob_idx,
    output logic                                    save_ready,
    output logic [CKPT_IDX_W-1:0]                   save_column,
    input  logic                                    resolve_valid,
    input  logic                                    resolve_mispredict,
    input  logic [CKPT_IDX_W-1:0]                   resolve_column,
    input  logic [ROB_IDX_W-1:0]                    resolve_rob_idx,
    output logic                                    resolve_success,
    input  logic                                    revert_valid,
    input  logic [ARCH_TAG_W-1:0]                   revert_arch,
    input  logic [PHYS_TAG_W-1:0]                   revert_safe_phys,
    input  logic [PHYS_TAG_W-1:0]                   revert_spec_phys
);

    map_array_t      working_r;
    map_snapshot_t   snap_r [CHECKPOINTS];
    checkpoint_ptr_t head_r;
    checkpoint_ptr_t tail_r;

    logic [CKPT_IDX_W-1:0]  head_idx_s;
    logic [CKPT_IDX_W-1:0]  tail_idx_s;
    logic                   full_s;
    logic                   hit_s;
    logic                   resolve_s;
    logic                   mispredict_s;
    logic                   release_s;
    logic                   group_ok_s;
    logic                   do_save_s;
    logic                   reclaim_s;
    checkpoint_ptr_t        misp_tail_s;
    logic [CHECKPOINTS-1:0] kill_mask_s;
    map_array_t             next_map_s;
    map_array_t             save_map_s;

    assign head_idx_s = head_r[CKPT_IDX_W-1:0];
    assign tail_idx_s = tail_r[CKPT_IDX_W-1:0];
    assign full_s     = (head_r[CKPT_IDX_W] != tail_r[CKPT_IDX_W]) && (head_idx_s == tail_idx_s);

    assign save_ready  = ~full_s;
    assign save_column = tail_idx_s;

    // Revert outranks everything, so a resolve in a revert cycle never hits.
    assign hit_s        = snap_r[resolve_column].valid && (snap_r[resolve_column].rob == resolve_rob_idx);
    assign resolve_s    = resolve_valid && !revert_valid;
    assign mispredict_s = resolve_s && resolve_mispredict && hit_s;
    assign release_s    = resolve_s && !resolve_mispredict && hit_s;
    assign resolve_success = resolve_s && hit_s;

    // A save while full drops the whole group, renames included.
    assign group_ok_s = !revert_valid && !mispredict_s && !(save_valid && full_s);
    assign do_save_s  = group_ok_s && save_valid;
    assign reclaim_s  = (head_r != tail_r) && !snap_r[head_idx_s].valid;

    rename_bypass_net u_bypass (
        .working       (working_r),
        .rd_src0_arch  (rd_src0_arch),
        .rd_src1_arch  (rd_src1_arch),
        .rd_dest_arch  (rd_dest_arch),
        .rename_valid  (rename_valid),
        .rename_phys   (rename_phys),
        .src0_phys     (rd_src0_phys),
        .src1_phys     (rd_src1_phys),
        .old_dest_phys (rd_old_dest_phys)
    );

    // Apply the group's renames in lane order; the snapshot image stops at save_lane.
    always_comb begin
        next_map_s = working_r;
        save_map_s = working_r;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            next_map_s[rd_dest_arch[k]] = (rename_valid[k] && (rd_dest_arch[k] != '0))
                                          ? rename_phys[k] : next_map_s[rd_dest_arch[k]];
            save_map_s[rd_dest_arch[k]] = (rename_valid[k] && (rd_dest_arch[k] != '0)
                                           && (LANE_IDX_W'(k) <= save_lane))
                                          ? rename_phys[k] : save_map_s[rd_dest_arch[k]];
        end
    end

    // Mispredict recovery: rebuild the tail pointer for the resolved column and
    // mark that column plus everything allocated after it, measured from head.
    always_comb begin
        logic [CKPT_IDX_W-1:0] col_off_v;
        logic [CKPT_IDX_W-1:0] slot_off_v;
        misp_tail_s = {(resolve_column >= head_idx_s) ? head_r[CKPT_IDX_W] : ~head_r[CKPT_IDX_W],
                       resolve_column};
        col_off_v   = resolve_column - head_idx_s;
        kill_mask_s = '0;
        for (int i = 0; i < CHECKPOINTS; i++) begin
            slot_off_v     = CKPT_IDX_W'(i) - head_idx_s;
            kill_mask_s[i] = (slot_off_v >= col_off_v);
        end
    end

    // Map, snapshot and pointer state; priority is revert, then mispredict, then normal flow.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            working_r <= identity_map();
            for (int i = 0; i < CHECKPOINTS; i++) begin
                snap_r[i] <= '0;
            end
            head_r <= '0;
            tail_r <= '0;
        end else begin
            if (reclaim_s) begin
                head_r <= ptr_inc(head_r);
            end
            if (revert_valid) begin
                if (revert_arch != '0) begin
                    working_r[revert_arch] <= revert_safe_phys;
                end
                for (int i = 0; i < CHECKPOINTS; i++) begin
                    snap_r[i].valid <= 1'b0;
                end
                head_r <= tail_r;
            end else if (mispredict_s) begin
                working_r <= snap_r[resolve_column].map;
                tail_r    <= misp_tail_s;
                for (int i = 0; i < CHECKPOINTS; i++) begin
                    if (kill_mask_s[i]) begin
                        snap_r[i].valid <= 1'b0;
                    end
                end
            end else begin
                if (group_ok_s) begin
                    working_r <= next_map_s;
                end
                if (release_s) begin
                    snap_r[resolve_column].valid <= 1'b0;
                end
                if (do_save_s) begin
                    snap_r[tail_idx_s] <= '{valid: 1'b1, rob: save_rob_idx, map: save_map_s};
                    tail_r             <= ptr_inc(tail_r);
                end
            end
        end
    end

`ifdef MAP_TABLE_CHECK_EN
    logic dut_error_r;
    logic err_revert_s;
    logic err_full_s;
    logic err_miss_s;
    logic err_rename_s;
    logic next_dut_error_s;

    assign err_revert_s     = revert_valid && (working_r[revert_arch] != revert_spec_phys);
    assign err_full_s       = save_valid && full_s;
    assign err_miss_s       = resolve_s && !hit_s;
    assign err_rename_s     = revert_valid && (|rename_valid);
    assign next_dut_error_s = err_revert_s || err_full_s || err_miss_s || err_rename_s;

    // Registered violation flag with a message naming the cause.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dut_error_r <= 1'b0;
        end else begin
            dut_error_r <= next_dut_error_s;
            if (err_revert_s) $display("map_table: revert spec mapping differs for arch %0d", revert_arch);
            if (err_full_s)   $display("map_table: save while full");
            if (err_miss_s)   $display("map_table: resolve miss on column %0d", resolve_column);
            if (err_rename_s) $display("map_table: rename during revert");
        end
    end

    assign DUT_error = dut_error_r;
`else
    logic spec_unused_s;
    assign spec_unused_s = ^revert_spec_phys;
    assign DUT_error     = 1'b0;
`endif

endmodule
